trade_signal_fsm: RTL and testbench
===================================

# trade_signal_fsm

Decision stage directly downstream of the 8-bit moving-average price filter. It consumes the filtered (short-window) price and keeps its own long-window average. It detects crossovers with hysteresis and tracks a FLAT/LONG position. Buy/sell orders are emitted on a valid/ready handshake toward the order/GPIO output stage, with a post-trade cooldown.

## Interface
- DATA_W, 8, price width (matches filter output)
- LONG_LOG2, 4, log2 of long window length (default 16 samples)
- HYST, 2, crossover hysteresis in price LSBs
- COOLDOWN, 8, accepted samples ignored for decisions after each executed order
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- avg_in  in  DATA_W  filtered price from the moving-average stage
- avg_valid  in  1  avg_in carries a new sample this cycle
- order_valid  out  1  order pending
- order_side  out  1  1 = buy, 0 = sell
- order_price  out  DATA_W  avg_in value that triggered the order
- order_ready  in  1  downstream accepts the order
- position_long  out  1  1 while holding a position
- warm  out  1  long window full; decisions enabled

## Operation
- Long average:
  - ring buffer of 2^LONG_LOG2 samples
  - running sum of DATA_W+LONG_LOG2 bits, unsigned, never overflows
  - each accepted sample updates the sum as sum − oldest + avg_in
  - long_avg register = sum >> LONG_LOG2 (truncating)
- Fill counter counts accepted samples up to 2^LONG_LOG2, then saturates. warm=1 once the counter is full.
- Comparisons use widened DATA_W+2-bit unsigned arithmetic. No wrap is permitted.
- States:
  - WARMUP: buffer filling. The sample that completes the fill is not evaluated. Next state is FLAT.
  - FLAT: a sample with cooldown==0 and avg_in > long_avg + HYST goes to WAIT_ACK with side=buy.
  - LONG: a sample with cooldown==0 and avg_in + HYST < long_avg goes to WAIT_ACK with side=sell.
  - WAIT_ACK: order_valid=1. side and price are held stable until order_ready. On handshake:
    - position_long toggles
    - cooldown loads COOLDOWN
    - state goes to LONG (after buy) or FLAT (after sell)
- Comparisons use long_avg as registered before the current sample is folded in. Equality at the hysteresis bound produces no order.
- Samples arriving in WAIT_ACK still update the buffer and sum, but are not evaluated.
- Cooldown decrements by 1 per accepted sample while in FLAT or LONG and nonzero.
- If a handshake and avg_valid occur in the same cycle, the handshake wins. Cooldown loads COOLDOWN and that sample does not decrement it.
- order_ready while order_valid=0 is ignored.

## Timing
- Reset values: order_valid=0, order_side=0, order_price=0, position_long=0, warm=0. Sum, counter, cooldown and buffer are cleared; state is WARMUP.
- Sample accepted in cycle N:
  - long_avg and warm update at edge N+1
  - a triggered order shows order_valid=1 from cycle N+1
- Handshake in cycle M: order_valid=0 and position_long updated from cycle M+1. A new order is possible no earlier than COOLDOWN+1 accepted samples later.
- rst in any state, including mid-WAIT_ACK, returns all outputs to reset values on the next edge. A pending order is discarded.
- Throughput: one sample per cycle. avg_valid is never back-pressured.

## Structure
- Shared package trade_pkg holds:
  - state enum (WARMUP, FLAT, LONG, WAIT_ACK)
  - side encoding constants SIDE_BUY=1, SIDE_SELL=0
  - default DATA_W
- Sub-module long_window_avg contains the ring buffer, running sum, fill counter, long_avg and warm. The top level holds the FSM, cooldown counter and order registers.

## Test plan
All scenarios use default parameters.
- Warm-up: rst, then 16 samples of 100 → warm=1 one cycle after the 16th sample; long_avg=100; no order_valid.
- Buy: warm at 100, then sample 103 → order_valid=1 next cycle with side=1, price=103. Outputs stay stable with order_ready=0 for 5 cycles. order_ready=1 → position_long=1 next cycle.
- Hysteresis boundary: warm at 100, FLAT, sample 102 → no order. Sample 103 → order.
- Cooldown and sell: after the buy above, feed 90s:
  - samples 1–8: no order (cooldown)
  - 9th sample: long_avg=95 → sell, price=90
- Reset mid-order: rst asserted during WAIT_ACK → next cycle order_valid=0, position_long=0, warm=0. 16 new samples are needed to re-warm.
- Width extreme: 16 samples of 255 → long_avg=255 with no sum overflow. Then sample 0 in FLAT → no order.

Source files
------------

// File: rtl/trade_pkg.sv
//----------------------------------------------------------------------------
// trade_pkg -- shared state, side encodings and default width for trade_signal_fsm
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package trade_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    FLAT     = 2'd1,
    LONG     = 2'd2,
    WAIT_ACK = 2'd3
  } state_e;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/trade_signal_fsm_if.sv
//----------------------------------------------------------------------------
// trade_signal_fsm_if -- price sample input, order handshake and status bundle
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface trade_signal_fsm_if
  import trade_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] avg_in;
  logic              avg_valid;
  logic              order_valid;
  logic              order_side;
  logic [DATA_W-1:0] order_price;
  logic              order_ready;
  logic              position_long;
  logic              warm;

  // master: the filter/order-stage side; slave: the decision block
  modport master (
    output avg_in, avg_valid, order_ready,
    input  order_valid, order_side, order_price, position_long, warm
  );

  modport slave (
    input  avg_in, avg_valid, order_ready,
    output order_valid, order_side, order_price, position_long, warm
  );

endinterface

`default_nettype wire

// File: rtl/trade_signal_fsm_long_window_avg.sv
//----------------------------------------------------------------------------
// long_window_avg -- ring buffer, running sum, fill counter and long average
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module long_window_avg
  import trade_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int LONG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] long_avg,
  output logic              warm,
  output logic              fill_done
);

  localparam int DEPTH = 1 << LONG_LOG2;
  localparam int SUM_W = DATA_W + LONG_LOG2;
  localparam logic [LONG_LOG2:0] FILL_FULL = (LONG_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]    ring_q [DEPTH];
  logic [DATA_W-1:0]    ring_d [DEPTH];
  logic [LONG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [LONG_LOG2:0]   fill_q, fill_d;
  logic [DATA_W-1:0]    long_avg_q, long_avg_d;

  // Slots start cleared, so the oldest entry reads zero until the window fills
  always_comb begin
    ring_d     = ring_q;
    wr_ptr_d   = wr_ptr_q;
    sum_d      = sum_q;
    fill_d     = fill_q;
    long_avg_d = long_avg_q;
    if (sample_valid) begin
      ring_d[wr_ptr_q] = sample_in;
      wr_ptr_d         = wr_ptr_q + LONG_LOG2'(1);
      sum_d            = sum_q - SUM_W'(ring_q[wr_ptr_q]) + SUM_W'(sample_in);
      long_avg_d       = DATA_W'(sum_d >> LONG_LOG2);
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + (LONG_LOG2+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      long_avg_q <= '0;
    end else begin
      ring_q     <= ring_d;
      wr_ptr_q   <= wr_ptr_d;
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      long_avg_q <= long_avg_d;
    end
  end

  assign long_avg  = long_avg_q;
  assign warm      = (fill_q == FILL_FULL);
  assign fill_done = sample_valid && (fill_q == FILL_FULL - (LONG_LOG2+1)'(1));

endmodule

`default_nettype wire

// File: rtl/trade_signal_fsm.sv
//----------------------------------------------------------------------------
// trade_signal_fsm -- hysteretic crossover FSM with FLAT/LONG position and cooldown
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module trade_signal_fsm
  import trade_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int LONG_LOG2 = 4,
  parameter int HYST      = 2,
  parameter int COOLDOWN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  trade_signal_fsm_if.slave  bus
);

  localparam logic [1:0] S_WARMUP   = 2'(WARMUP);
  localparam logic [1:0] S_FLAT     = 2'(FLAT);
  localparam logic [1:0] S_LONG     = 2'(LONG);
  localparam logic [1:0] S_WAIT_ACK = 2'(WAIT_ACK);

  localparam int CMP_W = DATA_W + 2;
  localparam int CD_W  = $clog2(COOLDOWN + 2);

  logic [DATA_W-1:0] long_avg;
  logic              warm;
  logic              fill_done;

  long_window_avg #(
    .DATA_W    (DATA_W),
    .LONG_LOG2 (LONG_LOG2)
  ) u_long_window_avg (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (bus.avg_in),
    .sample_valid (bus.avg_valid),
    .long_avg     (long_avg),
    .warm         (warm),
    .fill_done    (fill_done)
  );

  // Widened so neither price + HYST nor long_avg + HYST can wrap
  logic [CMP_W-1:0] price_w, avg_w, hyst_w;
  logic             buy_cross, sell_cross, handshake;

  assign price_w    = CMP_W'(bus.avg_in);
  assign avg_w      = CMP_W'(long_avg);
  assign hyst_w     = CMP_W'(HYST);
  assign buy_cross  = price_w > (avg_w + hyst_w);
  assign sell_cross = (price_w + hyst_w) < avg_w;

  logic [1:0]        state_q, state_d;
  logic [CD_W-1:0]   cooldown_q, cooldown_d;
  logic              order_valid_q, order_valid_d;
  logic              order_side_q, order_side_d;
  logic [DATA_W-1:0] order_price_q, order_price_d;
  logic              position_long_q, position_long_d;

  assign handshake = order_valid_q && bus.order_ready;

  always_comb begin
    state_d         = state_q;
    cooldown_d      = cooldown_q;
    order_valid_d   = order_valid_q;
    order_side_d    = order_side_q;
    order_price_d   = order_price_q;
    position_long_d = position_long_q;
    case (state_q)
      S_WARMUP: begin
        if (fill_done) begin
          state_d = S_FLAT;
        end
      end
      S_FLAT, S_LONG: begin
        if (bus.avg_valid) begin
          if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
          end else if ((state_q == S_FLAT) && buy_cross) begin
            state_d       = S_WAIT_ACK;
            order_valid_d = 1'b1;
            order_side_d  = SIDE_BUY;
            order_price_d = bus.avg_in;
          end else if ((state_q == S_LONG) && sell_cross) begin
            state_d       = S_WAIT_ACK;
            order_valid_d = 1'b1;
            order_side_d  = SIDE_SELL;
            order_price_d = bus.avg_in;
          end
        end
      end
      S_WAIT_ACK: begin
        if (handshake) begin
          order_valid_d   = 1'b0;
          position_long_d = ~position_long_q;
          cooldown_d      = CD_W'(COOLDOWN);
          state_d         = (order_side_q == SIDE_BUY) ? S_LONG : S_FLAT;
        end
      end
      default: state_d = S_WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_WARMUP;
      cooldown_q      <= '0;
      order_valid_q   <= 1'b0;
      order_side_q    <= 1'b0;
      order_price_q   <= '0;
      position_long_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cooldown_q      <= cooldown_d;
      order_valid_q   <= order_valid_d;
      order_side_q    <= order_side_d;
      order_price_q   <= order_price_d;
      position_long_q <= position_long_d;
    end
  end

  assign bus.order_valid   = order_valid_q;
  assign bus.order_side    = order_side_q;
  assign bus.order_price   = order_price_q;
  assign bus.position_long = position_long_q;
  assign bus.warm          = warm;

endmodule

`default_nettype wire

// File: tb/tb_trade_signal_fsm.sv
//----------------------------------------------------------------------------
// tb_trade_signal_fsm -- directed scenarios plus random walk against a window model
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_trade_signal_fsm;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int HYST     = 2;
  localparam int COOLDOWN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trade_signal_fsm_if #(.DATA_W(DATA_W)) bus ();

  trade_signal_fsm #(
    .DATA_W    (DATA_W),
    .LONG_LOG2 (4),
    .HYST      (HYST),
    .COOLDOWN  (COOLDOWN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the last DEPTH samples, a fill count, and the order/position book
  int win [DEPTH];
  int wp, fill, la, m_price, m_cd, total;
  bit m_pend, m_side, m_pos, m_ok, was_warm;

  function automatic int window_avg();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += win[i];
    return s / DEPTH;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win[i] = 0;
      wp = 0; fill = 0; m_cd = 0; m_price = 0;
      m_pend = 0; m_side = 0; m_pos = 0; m_ok = 1;
    end else begin
      la       = window_avg();
      was_warm = (fill >= DEPTH);
      if (m_pend && bus.order_ready) begin
        m_pend = 0;
        m_pos  = !m_pos;
        m_cd   = COOLDOWN;
      end else if (bus.avg_valid && was_warm && !m_pend) begin
        if (m_cd > 0) m_cd--;
        else if (!m_pos && int'(bus.avg_in) > la + HYST) begin
          m_pend = 1; m_side = 1; m_price = int'(bus.avg_in);
        end else if (m_pos && int'(bus.avg_in) + HYST < la) begin
          m_pend = 1; m_side = 0; m_price = int'(bus.avg_in);
        end
      end
      if (bus.avg_valid) begin
        win[wp] = int'(bus.avg_in);
        wp      = (wp + 1) % DEPTH;
        if (fill < DEPTH) fill++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model.order_valid", int'(bus.order_valid), int'(m_pend));
      check("model.position_long", int'(bus.position_long), int'(m_pos));
      check("model.warm", int'(bus.warm), int'(fill >= DEPTH));
      if (m_pend) begin
        check("model.order_side", int'(bus.order_side), int'(m_side));
        check("model.order_price", int'(bus.order_price), m_price);
      end
    end
  end

  task automatic cyc(input bit v, input int d, input bit rdy);
    bus.avg_valid   = v;
    bus.avg_in      = d[DATA_W-1:0];
    bus.order_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  int price;
  int step;

  initial begin
    bus.avg_valid   = 1'b0;
    bus.avg_in      = '0;
    bus.order_ready = 1'b0;
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("reset.order_valid", int'(bus.order_valid), 0);
    check("reset.order_side", int'(bus.order_side), 0);
    check("reset.order_price", int'(bus.order_price), 0);
    check("reset.position_long", int'(bus.position_long), 0);
    check("reset.warm", int'(bus.warm), 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) cyc(1, 100, 0);
    check("warmup.warm_after15", int'(bus.warm), 0);
    cyc(1, 100, 0);
    check("warmup.warm_after16", int'(bus.warm), 1);
    check("warmup.no_order", int'(bus.order_valid), 0);

    cyc(1, 102, 0);
    check("hyst.102_no_order", int'(bus.order_valid), 0);
    cyc(1, 103, 0);
    check("buy.order_valid", int'(bus.order_valid), 1);
    check("buy.side", int'(bus.order_side), 1);
    check("buy.price", int'(bus.order_price), 103);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      check("buy.hold_valid", int'(bus.order_valid), 1);
      check("buy.hold_side", int'(bus.order_side), 1);
      check("buy.hold_price", int'(bus.order_price), 103);
    end
    cyc(0, 0, 1);
    check("buy.ack_valid", int'(bus.order_valid), 0);
    check("buy.ack_position", int'(bus.position_long), 1);

    for (int i = 0; i < 8; i++) begin
      cyc(1, 90, 0);
      check("cooldown.no_order", int'(bus.order_valid), 0);
    end
    cyc(1, 90, 0);
    check("sell.order_valid", int'(bus.order_valid), 1);
    check("sell.side", int'(bus.order_side), 0);
    check("sell.price", int'(bus.order_price), 90);

    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    check("rst_mid.order_valid", int'(bus.order_valid), 0);
    check("rst_mid.position_long", int'(bus.position_long), 0);
    check("rst_mid.warm", int'(bus.warm), 0);
    for (int i = 0; i < 15; i++) cyc(1, 50, 0);
    check("rewarm.after15", int'(bus.warm), 0);
    cyc(1, 50, 0);
    check("rewarm.after16", int'(bus.warm), 1);

    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1, 255, 0);
    check("extreme.warm", int'(bus.warm), 1);
    cyc(1, 255, 0);
    check("extreme.255_no_order", int'(bus.order_valid), 0);
    cyc(1, 0, 0);
    check("extreme.zero_no_order", int'(bus.order_valid), 0);

    // Random walk with occasional large jumps, random ready and rare resets
    price = 128;
    for (int i = 0; i < 6000; i++) begin
      step = int'($urandom_range(0, 12)) - 6;
      if ($urandom_range(0, 49) == 0) step = step * 8;
      price += step;
      if (price < 0) price = 0;
      if (price > 255) price = 255;
      rst = ($urandom_range(0, 799) == 0);
      cyc($urandom_range(0, 3) != 0, price, $urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    cyc(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
